// File: rtl/imem_boot_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader.
// Holds the FSM state encoding and the stream framing constants.
// Imported by the loader top and its byte packer.
package imem_boot_loader_pkg;

    // Stream framing: 2 header bytes carry the word count, 4 bytes per word.
    localparam int HDR_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;
    localparam int BYTE_W         = 8;
    localparam int PACK_W         = BYTES_PER_WORD * BYTE_W;

    // Loader states, IDLE..ERR.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR0  = 3'd1,
        ST_HDR1  = 3'd2,
        ST_DATA  = 3'd3,
        ST_WRITE = 3'd4,
        ST_DONE  = 3'd5,
        ST_ERR   = 3'd6
    } boot_state_t;

endpackage

// File: rtl/imem_boot_loader_byte_word_packer.sv
// Packs a big-endian byte stream into 32-bit words (first byte lands in [31:24]).
// Latency: word register updated on the edge a byte is shifted in; word_full_o flags the 4th byte combinationally.
// Backpressure: none of its own; the caller only asserts shift_i on an accepted transfer.
module byte_word_packer
    import imem_boot_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              shift_i,
    input  logic [BYTE_W-1:0] byte_i,
    output logic [PACK_W-1:0] word_o,
    output logic              word_full_o
);

    localparam logic [1:0] IDX_LAST = 2'(BYTES_PER_WORD - 1);

    logic [PACK_W-1:0] word_q;
    logic [1:0]        idx_q;

    // Shift register and byte index; cleared on reset and at the start of every load.
    always_ff @(posedge clk) begin
        if (!rst_n || clr_i) begin
            word_q <= '0;
            idx_q  <= '0;
        end else if (shift_i) begin
            word_q <= {word_q[PACK_W-BYTE_W-1:0], byte_i};
            idx_q  <= idx_q + 2'd1;
        end
    end

    assign word_o      = word_q;
    assign word_full_o = shift_i && (idx_q == IDX_LAST);

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: streams a word-count header plus big-endian words into the IM, holding the CPU in reset until complete.
// Latency: 4th byte of a word accepted in cycle t -> im_we in t+1; last write in t -> done/cpu_rst_n in t+1.
// Backpressure: rx_ready low in IDLE, WRITE, DONE and ERR; bytes move only on rx_valid & rx_ready.
module imem_boot_loader
    import imem_boot_loader_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [WORD_W-1:0] im_wdata,
    output logic              cpu_rst_n,
    output logic              done,
    output logic              error,
    output logic [15:0]       words_loaded
);

    // Capacity is compared in 17 bits so that N == 2**16 style edge cases cannot alias.
    localparam logic [16:0]       CAPACITY = 17'd1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    boot_state_t       state_q;
    logic [15:0]       n_q;
    logic [15:0]       words_q;
    logic [ADDR_W-1:0] im_addr_q;
    logic              rx_ready_q;
    logic              im_we_q;
    logic              cpu_rst_n_q;
    logic              done_q;
    logic              error_q;

    logic              xfer;
    logic              load_start;
    logic [15:0]       n_d;
    logic [15:0]       words_d;
    logic [PACK_W-1:0] pk_word;
    logic              pk_full;

    assign xfer       = rx_valid && rx_ready_q;
    assign load_start = start && ((state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERR));
    assign n_d        = {n_q[15:8], rx_data};
    assign words_d    = words_q + 16'd1;

    byte_word_packer u_packer (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr_i       (load_start),
        .shift_i     (xfer && (state_q == ST_DATA)),
        .byte_i      (rx_data),
        .word_o      (pk_word),
        .word_full_o (pk_full)
    );

    // Loader FSM with all outputs registered; im_we is a single-cycle pulse tied to WRITE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            n_q         <= '0;
            words_q     <= '0;
            im_addr_q   <= '0;
            rx_ready_q  <= 1'b0;
            im_we_q     <= 1'b0;
            cpu_rst_n_q <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            im_we_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start) begin
                        state_q     <= ST_HDR0;
                        rx_ready_q  <= 1'b1;
                        words_q     <= '0;
                        im_addr_q   <= '0;
                        done_q      <= 1'b0;
                        error_q     <= 1'b0;
                        cpu_rst_n_q <= 1'b0;
                    end
                end
                ST_HDR0: begin
                    if (xfer) begin
                        n_q[15:8] <= rx_data;
                        state_q   <= ST_HDR1;
                    end
                end
                ST_HDR1: begin
                    if (xfer) begin
                        n_q <= n_d;
                        if (n_d == 16'd0) begin
                            // Empty image: release the CPU straight away.
                            state_q     <= ST_DONE;
                            rx_ready_q  <= 1'b0;
                            done_q      <= 1'b1;
                            cpu_rst_n_q <= 1'b1;
                        end else if ({1'b0, n_d} > CAPACITY) begin
                            state_q    <= ST_ERR;
                            rx_ready_q <= 1'b0;
                            error_q    <= 1'b1;
                        end else begin
                            state_q <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (pk_full) begin
                        state_q    <= ST_WRITE;
                        rx_ready_q <= 1'b0;
                        im_we_q    <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    words_q <= words_d;
                    if (words_d == n_q) begin
                        // Address is left on the last word so a full image never wraps to 0.
                        state_q     <= ST_DONE;
                        done_q      <= 1'b1;
                        cpu_rst_n_q <= 1'b1;
                    end else begin
                        state_q    <= ST_DATA;
                        rx_ready_q <= 1'b1;
                        im_addr_q  <= im_addr_q + ADDR_ONE;
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    rx_ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign rx_ready     = rx_ready_q;
    assign im_we        = im_we_q;
    assign im_addr      = im_addr_q;
    assign im_wdata     = WORD_W'(pk_word);
    assign cpu_rst_n    = cpu_rst_n_q;
    assign done         = done_q;
    assign error        = error_q;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: one 256-word instance and one 4-word instance.
// Inputs driven 1 time unit after the rising edge; outputs sampled at the same point.
// Failures counted and reported by immediate assertions; one summary line at the end.
module tb_imem_boot_loader;

    logic        clk = 1'b0;
    logic        rst_n;

    // Instance A: ADDR_W = 8
    logic        start_a, rx_valid_a, rx_ready_a, im_we_a, cpu_rst_n_a, done_a, error_a;
    logic [7:0]  rx_data_a, im_addr_a;
    logic [31:0] im_wdata_a;
    logic [15:0] words_a;

    // Instance B: ADDR_W = 2
    logic        start_b, rx_valid_b, rx_ready_b, im_we_b, cpu_rst_n_b, done_b, error_b;
    logic [7:0]  rx_data_b;
    logic [1:0]  im_addr_b;
    logic [31:0] im_wdata_b;
    logic [15:0] words_b;

    int n_cmp  = 0;
    int n_fail = 0;

    // Memory models fed by the write ports, plus event counters.
    logic [31:0] im_a [0:255];
    logic [31:0] im_b [0:3];
    logic [1:0]  addr_log_b [0:7];
    int we_cnt_a = 0;
    int we_cnt_b = 0;
    int xfer_a   = 0;

    always #5 clk = ~clk;

    imem_boot_loader #(.ADDR_W(8), .WORD_W(32)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .rx_data(rx_data_a), .rx_valid(rx_valid_a),
        .rx_ready(rx_ready_a), .im_we(im_we_a), .im_addr(im_addr_a), .im_wdata(im_wdata_a),
        .cpu_rst_n(cpu_rst_n_a), .done(done_a), .error(error_a), .words_loaded(words_a)
    );

    imem_boot_loader #(.ADDR_W(2), .WORD_W(32)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .rx_data(rx_data_b), .rx_valid(rx_valid_b),
        .rx_ready(rx_ready_b), .im_we(im_we_b), .im_addr(im_addr_b), .im_wdata(im_wdata_b),
        .cpu_rst_n(cpu_rst_n_b), .done(done_b), .error(error_b), .words_loaded(words_b)
    );

    always @(posedge clk) begin
        if (im_we_a === 1'b1) begin
            im_a[im_addr_a] = im_wdata_a;
            we_cnt_a++;
        end
        if (rx_valid_a === 1'b1 && rx_ready_a === 1'b1) xfer_a++;
        if (im_we_b === 1'b1) begin
            im_b[im_addr_b] = im_wdata_b;
            if (we_cnt_b < 8) addr_log_b[we_cnt_b] = im_addr_b;
            we_cnt_b++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one byte with rx_valid high and wait (bounded) for it to be accepted.
    task automatic send(input bit sel_b, input logic [7:0] b);
        int g;
        g = 0;
        if (sel_b) begin
            rx_data_b  = b;
            rx_valid_b = 1'b1;
            while (rx_ready_b !== 1'b1 && g < 50) begin tick(); g++; end
        end else begin
            rx_data_a  = b;
            rx_valid_a = 1'b1;
            while (rx_ready_a !== 1'b1 && g < 50) begin tick(); g++; end
        end
        if (g >= 50) begin
            n_cmp++;
            n_fail++;
            $display("FAIL rx_ready_timeout: observed no rx_ready in 50 cycles, expected rx_ready");
        end
        tick();
    endtask

    task automatic send_word(input bit sel_b, input logic [31:0] w);
        send(sel_b, w[31:24]);
        send(sel_b, w[23:16]);
        send(sel_b, w[15:8]);
        send(sel_b, w[7:0]);
    endtask

    task automatic pulse_start(input bit sel_b);
        if (sel_b) start_b = 1'b1; else start_a = 1'b1;
        tick();
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic chk_reset_a(input string tag);
        chk({tag, "_rx_ready"},  {31'd0, rx_ready_a},  32'd0);
        chk({tag, "_im_we"},     {31'd0, im_we_a},     32'd0);
        chk({tag, "_im_addr"},   {24'd0, im_addr_a},   32'd0);
        chk({tag, "_im_wdata"},  im_wdata_a,           32'd0);
        chk({tag, "_cpu_rst_n"}, {31'd0, cpu_rst_n_a}, 32'd0);
        chk({tag, "_done"},      {31'd0, done_a},      32'd0);
        chk({tag, "_error"},     {31'd0, error_a},     32'd0);
        chk({tag, "_words"},     {16'd0, words_a},     32'd0);
    endtask

    int base_we;
    int base_xfer;
    logic [7:0] t4 [0:9];

    initial begin
        rst_n = 1'b0;
        start_a = 1'b0; rx_valid_a = 1'b0; rx_data_a = 8'h00;
        start_b = 1'b0; rx_valid_b = 1'b0; rx_data_b = 8'h00;
        tick(); tick(); tick();
        chk_reset_a("rst");
        chk("rst_b_rx_ready", {31'd0, rx_ready_b}, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("idle_rx_ready", {31'd0, rx_ready_a}, 32'd0);

        // 1. Three-word image, rx_valid held high throughout.
        pulse_start(1'b0);
        chk("t1_hdr0_ready", {31'd0, rx_ready_a}, 32'd1);
        send(1'b0, 8'h00);
        send(1'b0, 8'h03);
        send_word(1'b0, 32'h2008_0005);
        send_word(1'b0, 32'h2009_0007);
        send_word(1'b0, 32'h0109_5020);
        rx_valid_a = 1'b0;
        chk("t1_last_we",    {31'd0, im_we_a},     32'd1);
        chk("t1_last_addr",  {24'd0, im_addr_a},   32'd2);
        chk("t1_last_wdata", im_wdata_a,           32'h0109_5020);
        chk("t1_done_early", {31'd0, done_a},      32'd0);
        tick();
        chk("t1_done",       {31'd0, done_a},      32'd1);
        chk("t1_cpu_rst_n",  {31'd0, cpu_rst_n_a}, 32'd1);
        chk("t1_words",      {16'd0, words_a},     32'd3);
        chk("t1_we_off",     {31'd0, im_we_a},     32'd0);
        chk("t1_we_count",   32'(we_cnt_a),        32'd3);
        chk("t1_im0",        im_a[0],              32'h2008_0005);
        chk("t1_im1",        im_a[1],              32'h2009_0007);
        chk("t1_im2",        im_a[2],              32'h0109_5020);

        // 2. Empty image: HDR1 goes straight to DONE.
        pulse_start(1'b0);
        chk("t2_done_drop",  {31'd0, done_a},      32'd0);
        chk("t2_cpu_drop",   {31'd0, cpu_rst_n_a}, 32'd0);
        chk("t2_hdr0_ready", {31'd0, rx_ready_a},  32'd1);
        send(1'b0, 8'h00);
        send(1'b0, 8'h00);
        rx_valid_a = 1'b0;
        chk("t2_done",       {31'd0, done_a},      32'd1);
        chk("t2_words",      {16'd0, words_a},     32'd0);
        chk("t2_we_count",   32'(we_cnt_a),        32'd3);
        chk("t2_rx_ready",   {31'd0, rx_ready_a},  32'd0);

        // 3. Count 257 exceeds the 256-word capacity.
        pulse_start(1'b0);
        send(1'b0, 8'h01);
        send(1'b0, 8'h01);
        rx_valid_a = 1'b0;
        chk("t3_error",      {31'd0, error_a},     32'd1);
        chk("t3_cpu_rst_n",  {31'd0, cpu_rst_n_a}, 32'd0);
        chk("t3_rx_ready",   {31'd0, rx_ready_a},  32'd0);
        chk("t3_done",       {31'd0, done_a},      32'd0);
        pulse_start(1'b0);
        chk("t3_error_clr",  {31'd0, error_a},     32'd0);
        chk("t3_hdr0_ready", {31'd0, rx_ready_a},  32'd1);

        // 4. N=2 with rx_valid toggling and a start pulse mid-DATA.
        base_we   = we_cnt_a;
        base_xfer = xfer_a;
        t4[0] = 8'h00; t4[1] = 8'h02;
        t4[2] = 8'hAA; t4[3] = 8'hBB; t4[4] = 8'hCC; t4[5] = 8'hDD;
        t4[6] = 8'h11; t4[7] = 8'h22; t4[8] = 8'h33; t4[9] = 8'h44;
        for (int i = 0; i < 10; i++) begin
            send(1'b0, t4[i]);
            rx_valid_a = 1'b0;
            if (i == 3) start_a = 1'b1;
            tick();
            start_a = 1'b0;
        end
        chk("t4_done",       {31'd0, done_a},      32'd1);
        chk("t4_words",      {16'd0, words_a},     32'd2);
        chk("t4_we_count",   32'(we_cnt_a - base_we),    32'd2);
        chk("t4_xfer_count", 32'(xfer_a - base_xfer),    32'd10);
        chk("t4_im0",        im_a[0],              32'hAABB_CCDD);
        chk("t4_im1",        im_a[1],              32'h1122_3344);

        // 5. Reset asserted while the 3rd byte of the first word is offered.
        pulse_start(1'b0);
        send(1'b0, 8'h00);
        send(1'b0, 8'h02);
        send(1'b0, 8'hDE);
        send(1'b0, 8'hAD);
        rx_data_a  = 8'hBE;
        rx_valid_a = 1'b1;
        rst_n      = 1'b0;
        tick();
        chk_reset_a("t5_rst");
        rst_n      = 1'b1;
        rx_valid_a = 1'b0;
        tick();
        base_we = we_cnt_a;
        pulse_start(1'b0);
        send(1'b0, 8'h00);
        send(1'b0, 8'h01);
        send_word(1'b0, 32'h1234_5678);
        rx_valid_a = 1'b0;
        chk("t5_we",         {31'd0, im_we_a},     32'd1);
        chk("t5_addr",       {24'd0, im_addr_a},   32'd0);
        tick();
        chk("t5_done",       {31'd0, done_a},      32'd1);
        chk("t5_words",      {16'd0, words_a},     32'd1);
        chk("t5_we_count",   32'(we_cnt_a - base_we), 32'd1);
        chk("t5_im0",        im_a[0],              32'h1234_5678);
        chk("t5_im1_kept",   im_a[1],              32'h1122_3344);

        // 6. Four-word instance filled to capacity, then one word too many.
        pulse_start(1'b1);
        send(1'b1, 8'h00);
        send(1'b1, 8'h04);
        send_word(1'b1, 32'h1000_0000);
        send_word(1'b1, 32'h1100_0001);
        send_word(1'b1, 32'h1200_0002);
        send_word(1'b1, 32'h1300_0003);
        rx_valid_b = 1'b0;
        chk("t6_last_we",    {31'd0, im_we_b},     32'd1);
        chk("t6_last_addr",  {30'd0, im_addr_b},   32'd3);
        tick();
        chk("t6_done",       {31'd0, done_b},      32'd1);
        chk("t6_cpu_rst_n",  {31'd0, cpu_rst_n_b}, 32'd1);
        chk("t6_words",      {16'd0, words_b},     32'd4);
        chk("t6_we_count",   32'(we_cnt_b),        32'd4);
        chk("t6_addr_hold",  {30'd0, im_addr_b},   32'd3);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t6_addr_log%0d", i), {30'd0, addr_log_b[i]}, 32'(i));
        end
        chk("t6_im0",        im_b[0],              32'h1000_0000);
        chk("t6_im3",        im_b[3],              32'h1300_0003);
        tick();
        chk("t6_no_wrap",    32'(we_cnt_b),        32'd4);
        pulse_start(1'b1);
        send(1'b1, 8'h00);
        send(1'b1, 8'h05);
        rx_valid_b = 1'b0;
        chk("t6_err_n5",     {31'd0, error_b},     32'd1);
        chk("t6_err_cpu",    {31'd0, cpu_rst_n_b}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
